// File: rtl/ift_sram_pkg.sv
// Shared types and elaboration helpers for the taint-tracking SRAM bank.
package ift_sram_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // Word address width for a given depth.
  function automatic int unsigned calc_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Number of conservative-taint regions.
  function automatic int unsigned calc_num_regions(input int unsigned depth,
                                                   input int unsigned region_words);
    return depth / region_words;
  endfunction

  // Region index width, at least one bit even with a single region.
  function automatic int unsigned calc_rw(input int unsigned depth,
                                          input int unsigned region_words);
    int unsigned n;
    n = depth / region_words;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Region r can be hit by an address whose region field is addr_region
  // when every untainted region bit agrees.
  function automatic logic region_match(input int unsigned r,
                                        input int unsigned addr_region,
                                        input int unsigned addr_region_taint);
    return ((r ^ addr_region) & ~addr_region_taint) == 32'd0;
  endfunction

endpackage

// File: rtl/ift_sram_rd_pipe.sv
// Fixed-latency response pipe carrying valid, data and per-plane taint.
module ift_sram_rd_pipe #(
  parameter int unsigned Width     = 64,
  parameter int unsigned NumTaints = 2,
  parameter int unsigned Latency   = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              valid,
  input  logic [Width-1:0]                  data,
  input  logic [NumTaints-1:0][Width-1:0]   taint,
  output logic                              q_valid,
  output logic [Width-1:0]                  q_data,
  output logic [NumTaints-1:0][Width-1:0]   q_taint
);

  logic                            valid_q [Latency];
  logic [Width-1:0]                data_q  [Latency];
  logic [NumTaints-1:0][Width-1:0] taint_q [Latency];

  // Shift stages; an invalid entry always carries zero data and taint.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Latency; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        taint_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid;
      data_q[0]  <= valid ? data : '0;
      taint_q[0] <= valid ? taint : '0;
      for (int unsigned i = 1; i < Latency; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
        taint_q[i] <= taint_q[i-1];
      end
    end
  end

  assign q_valid = valid_q[Latency-1];
  assign q_data  = data_q[Latency-1];
  assign q_taint = taint_q[Latency-1];

endmodule

// File: rtl/ift_sram_bank.sv
// Single-port data+taint SRAM bank with region-granular conservative
// tainting for tainted write addresses and a post-reset clearing sweep.
module ift_sram_bank
  import ift_sram_pkg::*;
#(
  parameter int unsigned Width       = 64,
  parameter int unsigned Depth       = 256,
  parameter int unsigned NumTaints   = 2,
  parameter int unsigned ReadLatency = 1,
  parameter int unsigned RegionWords = 16,
  localparam int unsigned Aw         = calc_aw(Depth),
  localparam int unsigned NumRegions = calc_num_regions(Depth, RegionWords),
  localparam int unsigned Rw         = calc_rw(Depth, RegionWords)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              req_i,
  output logic                              gnt_o,
  input  logic                              write_i,
  input  logic [Aw-1:0]                     addr_i,
  input  logic [Width-1:0]                  wdata_i,
  input  logic [Width-1:0]                  wmask_i,
  output logic                              rvalid_o,
  output logic [Width-1:0]                  rdata_o,
  input  logic [NumTaints-1:0]              req_i_taint,
  input  logic [NumTaints-1:0]              write_i_taint,
  input  logic [NumTaints-1:0][Aw-1:0]      addr_i_taint,
  input  logic [NumTaints-1:0][Width-1:0]   wdata_i_taint,
  input  logic [NumTaints-1:0][Width-1:0]   wmask_i_taint,
  output logic [NumTaints-1:0][Width-1:0]   rdata_o_taint,
  output logic                              busy_o
);

  localparam int unsigned Ow = $clog2(RegionWords);

  state_e          state_q, state_d;
  logic [Aw-1:0]   sweep_q, sweep_d;

  logic [NumTaints-1:0][NumRegions-1:0] region_flag_q;

  logic [Width-1:0]                mem_data  [Depth];
  logic [NumTaints-1:0][Width-1:0] mem_taint [Depth];

  logic [Rw-1:0]                   addr_region;
  logic [NumTaints-1:0][Rw-1:0]    addr_region_taint;
  logic [NumTaints-1:0]            trigger;
  logic [NumTaints-1:0]            req_side;

  logic                            wr_en;
  logic [Aw-1:0]                   wr_addr;
  logic [Width-1:0]                wr_data;
  logic [Width-1:0]                wr_bmask;
  logic [NumTaints-1:0][Width-1:0] wr_taint;

  logic [Width-1:0]                rd_data;
  logic [NumTaints-1:0][Width-1:0] rd_taint;

  assign addr_region = Rw'(addr_i >> Ow);

  // State and sweep counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Sweep every word once after reset, then accept requests forever.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    gnt_o   = 1'b0;
    busy_o  = 1'b1;
    unique case (state_q)
      INIT: begin
        sweep_d = sweep_q + Aw'(1);
        if (sweep_q == Aw'(Depth - 1)) state_d = READY;
      end
      READY: begin
        gnt_o  = req_i;
        busy_o = 1'b0;
      end
      default: state_d = INIT;
    endcase
  end

  // Per-plane region trigger and request-side taint broadcast for reads.
  always_comb begin
    addr_region_taint = '0;
    trigger           = '0;
    req_side          = '0;
    for (int unsigned t = 0; t < NumTaints; t++) begin
      addr_region_taint[t] = Rw'(addr_i_taint[t] >> Ow);
      trigger[t] = (state_q == READY)
                 & (req_i | req_i_taint[t])
                 & (write_i | write_i_taint[t])
                 & (|addr_i_taint[t])
                 & (|(wmask_i | wmask_i_taint[t]));
      req_side[t] = region_flag_q[t][addr_region] | (|addr_i_taint[t])
                  | req_i_taint[t] | write_i_taint[t];
    end
  end

  // Sticky region flags; a read in the trigger cycle sees the old value.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      region_flag_q <= '0;
    end else begin
      for (int unsigned t = 0; t < NumTaints; t++) begin
        for (int unsigned r = 0; r < NumRegions; r++) begin
          if (trigger[t] && region_match(r, 32'(addr_region), 32'(addr_region_taint[t]))) begin
            region_flag_q[t][r] <= 1'b1;
          end
        end
      end
    end
  end

  // Write port shared by the clearing sweep and granted writes.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = addr_i;
    wr_data  = wdata_i;
    wr_bmask = wmask_i;
    wr_taint = '0;
    if (state_q == INIT) begin
      wr_en    = 1'b1;
      wr_addr  = sweep_q;
      wr_data  = '0;
      wr_bmask = '1;
    end else if (gnt_o && write_i) begin
      wr_en = 1'b1;
      for (int unsigned t = 0; t < NumTaints; t++) begin
        wr_taint[t] = (wmask_i & (wdata_i_taint[t] | wmask_i_taint[t]))
                    | (~wmask_i & (mem_taint[addr_i][t] | wmask_i_taint[t]));
      end
    end
  end

  // Storage update; no writes while reset is held.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en) begin
      mem_data[wr_addr]  <= (mem_data[wr_addr] & ~wr_bmask) | (wr_data & wr_bmask);
      mem_taint[wr_addr] <= wr_taint;
    end
  end

  // Read response assembled at grant; write responses carry zeros.
  always_comb begin
    rd_data  = '0;
    rd_taint = '0;
    if (!write_i) begin
      rd_data = mem_data[addr_i];
      for (int unsigned t = 0; t < NumTaints; t++) begin
        rd_taint[t] = mem_taint[addr_i][t] | {Width{req_side[t]}};
      end
    end
  end

  ift_sram_rd_pipe #(
    .Width     (Width),
    .NumTaints (NumTaints),
    .Latency   (ReadLatency)
  ) u_rd_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid   (gnt_o),
    .data    (rd_data),
    .taint   (rd_taint),
    .q_valid (rvalid_o),
    .q_data  (rdata_o),
    .q_taint (rdata_o_taint)
  );

endmodule

// File: tb/tb_ift_sram_bank.sv
// Scoreboard bench: two banks (read latency 1 and 3) share one stimulus stream.
module tb_ift_sram_bank;

  localparam logic [63:0] ONES = '1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_ni, req_i, write_i;
  logic [7:0]       addr_i;
  logic [63:0]      wdata_i, wmask_i;
  logic [1:0]       req_i_taint, write_i_taint;
  logic [1:0][7:0]  addr_i_taint;
  logic [1:0][63:0] wdata_i_taint, wmask_i_taint;

  logic             gnt1, rvalid1, busy1;
  logic [63:0]      rdata1;
  logic [1:0][63:0] rtaint1;
  logic             gnt3, rvalid3, busy3;
  logic [63:0]      rdata3;
  logic [1:0][63:0] rtaint3;

  ift_sram_bank #(.Width(64), .Depth(256), .NumTaints(2), .ReadLatency(1), .RegionWords(16)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt1), .write_i(write_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .wmask_i(wmask_i), .rvalid_o(rvalid1),
    .rdata_o(rdata1), .req_i_taint(req_i_taint), .write_i_taint(write_i_taint),
    .addr_i_taint(addr_i_taint), .wdata_i_taint(wdata_i_taint),
    .wmask_i_taint(wmask_i_taint), .rdata_o_taint(rtaint1), .busy_o(busy1));

  ift_sram_bank #(.Width(64), .Depth(256), .NumTaints(2), .ReadLatency(3), .RegionWords(16)) dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt3), .write_i(write_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .wmask_i(wmask_i), .rvalid_o(rvalid3),
    .rdata_o(rdata3), .req_i_taint(req_i_taint), .write_i_taint(write_i_taint),
    .addr_i_taint(addr_i_taint), .wdata_i_taint(wdata_i_taint),
    .wmask_i_taint(wmask_i_taint), .rdata_o_taint(rtaint3), .busy_o(busy3));

  typedef struct {
    int unsigned due;
    logic [63:0] d;
    logic [63:0] t0;
    logic [63:0] t1;
  } exp_t;

  typedef struct packed {
    logic [1:0]       rq_t;
    logic [1:0]       wr_t;
    logic [1:0][7:0]  at;
    logic [1:0][63:0] wdt;
    logic [1:0][63:0] wmt;
  } tin_t;

  exp_t q1[$];
  exp_t q3[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rvalid1 === 1'b1) begin
      if (q1.size() == 0) chk("L1 stray rvalid", 64'(rvalid1), 64'd0);
      else begin
        e = q1.pop_front();
        chk("L1 latency", 64'(cyc), 64'(e.due));
        chk("L1 rdata", rdata1, e.d);
        chk("L1 taint0", rtaint1[0], e.t0);
        chk("L1 taint1", rtaint1[1], e.t1);
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (rvalid3 === 1'b1) begin
      if (q3.size() == 0) chk("L3 stray rvalid", 64'(rvalid3), 64'd0);
      else begin
        e = q3.pop_front();
        chk("L3 latency", 64'(cyc), 64'(e.due));
        chk("L3 rdata", rdata3, e.d);
        chk("L3 taint0", rtaint3[0], e.t0);
        chk("L3 taint1", rtaint3[1], e.t1);
      end
    end
  end

  task automatic issue(input logic rq, input logic wr, input logic [7:0] a,
                       input logic [63:0] wd, input logic [63:0] wm, input tin_t tin,
                       input logic [63:0] ed, input logic [63:0] et0, input logic [63:0] et1,
                       input bit push3);
    @(posedge clk); #1;
    req_i = rq; write_i = wr; addr_i = a; wdata_i = wd; wmask_i = wm;
    req_i_taint = tin.rq_t; write_i_taint = tin.wr_t; addr_i_taint = tin.at;
    wdata_i_taint = tin.wdt; wmask_i_taint = tin.wmt;
    @(negedge clk);
    chk("gnt L1", 64'(gnt1), 64'(rq));
    chk("gnt L3", 64'(gnt3), 64'(rq));
    if (rq) begin
      q1.push_back('{due: cyc + 1, d: ed, t0: et0, t1: et1});
      if (push3) q3.push_back('{due: cyc + 3, d: ed, t0: et0, t1: et1});
    end
  endtask

  task automatic rd(input logic [7:0] a, input tin_t tin,
                    input logic [63:0] ed, input logic [63:0] et0, input logic [63:0] et1);
    issue(1'b1, 1'b0, a, 64'd0, 64'd0, tin, ed, et0, et1, 1'b1);
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] wd, input logic [63:0] wm,
                    input tin_t tin);
    issue(1'b1, 1'b1, a, wd, wm, tin, 64'd0, 64'd0, 64'd0, 1'b1);
  endtask

  task automatic clear_inputs();
    req_i = 1'b0; write_i = 1'b0; addr_i = '0; wdata_i = '0; wmask_i = '0;
    req_i_taint = '0; write_i_taint = '0; addr_i_taint = '0;
    wdata_i_taint = '0; wmask_i_taint = '0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    clear_inputs();
    rst_ni = 1'b0; req_i = 1'b1; addr_i = 8'h05;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst busy L1", 64'(busy1), 64'd1);
    chk("rst gnt L1", 64'(gnt1), 64'd0);
    chk("rst rvalid L1", 64'(rvalid1), 64'd0);
    chk("rst rdata L1", rdata1, 64'd0);
    chk("rst taint L1", rtaint1[0] | rtaint1[1], 64'd0);
    chk("rst busy L3", 64'(busy3), 64'd1);
    chk("rst gnt L3", 64'(gnt3), 64'd0);
    chk("rst rvalid L3", 64'(rvalid3), 64'd0);
    chk("rst rdata L3", rdata3, 64'd0);
    chk("rst taint L3", rtaint3[0] | rtaint3[1], 64'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  // Counts busy cycles with a read request held high; none may be granted.
  task automatic count_init();
    int unsigned n1, n3, gbad;
    n1 = 0; n3 = 0; gbad = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (busy1) begin n1++; if (gnt1) gbad++; end
      if (busy3) begin n3++; if (gnt3) gbad++; end
      if (!busy1 && !busy3) break;
    end
    req_i = 1'b0;
    chk("INIT length L1", 64'(n1), 64'd256);
    chk("INIT length L3", 64'(n3), 64'd256);
    chk("INIT gnt", 64'(gbad), 64'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    tin_t tn;
    rst_ni = 1'b0;
    clear_inputs();

    // Reset, abort INIT at cycle 100, then a full sweep must follow.
    apply_reset();
    repeat (100) @(posedge clk);
    apply_reset();
    count_init();

    tn = '0;
    rd(8'h05, tn, 64'd0, 64'd0, 64'd0);
    tn.wdt[0] = 64'hFF00_0000_0000_0000;
    wr(8'h10, 64'hDEADBEEF_00000000, 64'hFFFFFFFF_00000000, tn);
    tn = '0;
    rd(8'h10, tn, 64'hDEADBEEF_00000000, 64'hFF00_0000_0000_0000, 64'd0);

    // Low address bits tainted: only region 4 of plane 1.
    tn.at[1] = 8'h03;
    wr(8'h40, 64'h1111, ONES, tn);
    tn = '0;
    rd(8'h45, tn, 64'd0, 64'd0, ONES);
    rd(8'h10, tn, 64'hDEADBEEF_00000000, 64'hFF00_0000_0000_0000, 64'd0);
    rd(8'h40, tn, 64'h1111, 64'd0, ONES);

    // Top region bit tainted: regions 2 and 10 of plane 0.
    tn.at[0] = 8'h80;
    wr(8'h20, 64'h2222, ONES, tn);
    tn = '0;
    rd(8'h25, tn, 64'd0, ONES, 64'd0);
    rd(8'hA5, tn, 64'd0, ONES, 64'd0);
    rd(8'h35, tn, 64'd0, 64'd0, 64'd0);
    rd(8'h20, tn, 64'h2222, ONES, 64'd0);

    // Phantom write: not granted, no store, but flags region 6 of plane 1.
    tn.rq_t[1] = 1'b1; tn.at[1] = 8'h01;
    issue(1'b0, 1'b1, 8'h60, 64'h5555, ONES, tn, 64'd0, 64'd0, 64'd0, 1'b1);
    tn = '0;
    rd(8'h60, tn, 64'd0, 64'd0, ONES);

    // Request-side taint on plain reads broadcasts without flagging.
    tn.at[1] = 8'h01;
    rd(8'h10, tn, 64'hDEADBEEF_00000000, 64'hFF00_0000_0000_0000, ONES);
    tn = '0;
    rd(8'h15, tn, 64'd0, 64'd0, 64'd0);
    tn.rq_t[0] = 1'b1;
    rd(8'h35, tn, 64'd0, ONES, 64'd0);

    // Masked and unmasked taint merge.
    tn = '0; tn.wdt[0] = 64'h0F; tn.wmt[0] = 64'hFF00;
    wr(8'h11, 64'hAB, 64'hFF, tn);
    tn = '0;
    rd(8'h11, tn, 64'hAB, 64'hFF0F, 64'd0);
    wr(8'h11, 64'hCD00, 64'hFF00, tn);
    rd(8'h11, tn, 64'hCDAB, 64'h000F, 64'd0);

    // Tainted write strobe on a read: regions 6 and 7 of plane 0.
    tn.wr_t[0] = 1'b1; tn.at[0] = 8'h10;
    issue(1'b1, 1'b0, 8'h70, 64'd0, ONES, tn, 64'd0, ONES, 64'd0, 1'b1);
    tn = '0;
    rd(8'h65, tn, 64'd0, ONES, ONES);
    rd(8'h75, tn, 64'd0, ONES, 64'd0);

    // Back-to-back reads.
    rd(8'h10, tn, 64'hDEADBEEF_00000000, 64'hFF00_0000_0000_0000, 64'd0);
    rd(8'h45, tn, 64'd0, 64'd0, ONES);
    rd(8'h11, tn, 64'hCDAB, 64'h000F, 64'd0);
    rd(8'h05, tn, 64'd0, 64'd0, 64'd0);
    idle();
    repeat (6) @(posedge clk);

    // Reset while a latency-3 read is in flight: it must be dropped.
    issue(1'b1, 1'b0, 8'h10, 64'd0, 64'd0, tn,
          64'hDEADBEEF_00000000, 64'hFF00_0000_0000_0000, 64'd0, 1'b0);
    apply_reset();
    count_init();
    rd(8'h10, tn, 64'd0, 64'd0, 64'd0);
    rd(8'h45, tn, 64'd0, 64'd0, 64'd0);
    idle();

    for (int i = 0; i < 20 && (q1.size() != 0 || q3.size() != 0); i++) @(negedge clk);
    chk("L1 queue drained", 64'(q1.size()), 64'd0);
    chk("L3 queue drained", 64'(q3.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ift_sram_bank.md
Name: ift_sram_bank

Overview:
- Synthesizable, parametrised successor to the DPI-preloaded conservative taint SRAM.
- Word-addressed single-port data+taint memory: N taint planes, valid-tagged pipelined read path (configurable latency), post-reset taint-clear sweep.
- Region-granular conservative tainting replaces whole-memory tainting.
- Sits behind the cellift-instrumented memory adapters of the fuzzing SoC; no DPI, no associative arrays.

Parameters:
- Width, 64, data word width in bits (multiple of 8).
- Depth, 256, number of words (power of two, >= RegionWords).
- NumTaints, 2, number of independent taint planes (>= 1).
- ReadLatency, 1, cycles from accepted request to rvalid_o (1..4).
- RegionWords, 16, words per conservative-taint region (power of two); NumRegions = Depth/RegionWords.
- Derived: Aw = $clog2(Depth), Rw = $clog2(NumRegions) (min 1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- write_i  in  1  1=write, 0=read.
- addr_i  in  Aw  word address.
- wdata_i  in  Width  write data.
- wmask_i  in  Width  bit write mask.
- rvalid_o  out  1  response valid, ReadLatency cycles after grant.
- rdata_o  out  Width  read data (0 for write responses).
- req_i_taint  in  NumTaints  taint of req_i.
- write_i_taint  in  NumTaints  taint of write_i.
- addr_i_taint  in  NumTaints x Aw  taint of addr_i.
- wdata_i_taint  in  NumTaints x Width  taint of wdata_i.
- wmask_i_taint  in  NumTaints x Width  taint of wmask_i.
- rdata_o_taint  out  NumTaints x Width  taint of rdata_o.
- busy_o  out  1  high during INIT sweep.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is synchronous, active-low.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, rdata_o_taint=0, busy_o=1.
  - All region flags cleared; FSM enters INIT with sweep counter=0.
  - Reset mid-sweep or mid-read restarts INIT and drops in-flight responses.

FSM:
- INIT: each cycle writes data=0 and all taint planes=0 at the sweep counter address, then increments.
  - After Depth cycles (counter wraps at Depth-1), go to READY.
  - gnt_o=0, busy_o=1 throughout.
- READY: gnt_o = req_i, combinational; busy_o=0. No exit except reset.

Granted write:
- Data: mem[addr][i] <= wdata_i[i] where wmask_i[i].
- Taint plane t, per bit i:
  - if wmask_i[i]: taint <= wdata_i_taint[t][i] | wmask_i_taint[t][i].
  - else: taint <= taint | wmask_i_taint[t][i].
- Response: rvalid_o pulses after ReadLatency with rdata_o=0, rdata_o_taint=0.

Granted read:
- After ReadLatency cycles: rvalid_o=1, rdata_o=mem[addr].
- rdata_o_taint[t] = memtaint[t][addr] | {Width{region_flag[t][addr_region] | |addr_i_taint[t] | req_i_taint[t] | write_i_taint[t]}}.
  - The request-side terms are captured at grant and piped alongside the data.
- Back-to-back reads each cycle yield back-to-back rvalid_o.

Conservative region tainting (per plane t, READY only):
- Trigger: (req_i | req_i_taint[t]) & (write_i | write_i_taint[t]) & |(addr_i_taint[t]) & |(wmask_i | wmask_i_taint[t]).
  - This fires even when req_i=0 (tainted phantom request).
- On trigger, set region_flag[t][r] for every r with ((r ^ addr_region) & ~addr_region_taint) == 0.
  - addr_region and addr_region_taint are the top Rw bits of addr_i and addr_i_taint[t].
  - If only low (in-region) address bits are tainted, exactly one region is flagged.
- Flags are sticky until reset.
- Simultaneous trigger and read of the same region in one cycle: the read does not see the new flag. Flag update is visible from the next accepted request.

Decomposition:
- Package ift_sram_pkg holds:
  - FSM enum (INIT, READY).
  - Function region_match(r, addr_region, addr_region_taint).
  - Localparam helpers for Aw, Rw, NumRegions.
- One sub-module, ift_sram_rd_pipe: ReadLatency-deep shift of {valid, data, NumTaints x taint}; resettable valid, data zeroed when invalid.

Test Plan:
- Reset, then poll: busy_o=1 and gnt_o=0 for exactly 256 cycles. Read addr 0x05 -> rdata_o=0, rdata_o_taint=0, rvalid_o at grant+1.
- Write addr 0x10, wdata=0xDEADBEEF_00000000, wmask=0xFFFFFFFF_00000000, wdata_i_taint[0]=0xFF00_0000_0000_0000; read 0x10 -> rdata_o=0xDEADBEEF_00000000, taint[0]=0xFF00000000000000, taint[1]=0.
- Write with addr_i_taint[1]=0x03 (low bits) at addr 0x40 -> only region 4 flagged in plane 1. Read 0x45 -> taint[1] all-ones. Read 0x10 -> taint[1]=0. Plane 0 unaffected.
- Write with addr_i_taint[0]=0x80 at addr 0x20 -> regions 2 and 10 flagged. Reads of 0x25 and 0xA5 -> taint[0] all-ones; read 0x35 -> taint[0]=0.
- ReadLatency=3: reads on 4 consecutive cycles -> 4 consecutive rvalid_o starting 3 cycles after the first grant, in order.
- Assert rst_ni=0 during INIT at cycle 100 and during an in-flight read -> no rvalid_o after reset; INIT restarts and lasts a full 256 cycles.
